result_logger: RTL and testbench
================================

RESULT_LOGGER -- requirements
Module: result_logger

Interface
REQ-001 SHALL have parameter DEPTH, default 8, number of log entries (power of two, 2..64).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset; synchronous and active-high.
REQ-004 SHALL have port clear  input  1  synchronous flush of all entries and the overflow flag.
REQ-005 SHALL have port result_ready  input  1  CPU result-valid level; capture is triggered on its rising edge.
REQ-006 SHALL have ports pc_in, opcode_in, operand_A_in, operand_B_in, result_in  input  8 each  CPU fields sampled at capture.
REQ-007 SHALL have ports carry_in, borrow_in  input  1 each  CPU flags sampled at capture.
REQ-008 SHALL have port log_ready  input  1  consumer accepts the head entry.
REQ-009 SHALL have port log_valid  output  1  head entry present (count != 0).
REQ-010 SHALL have ports log_pc, log_opcode, log_A, log_B, log_result  output  8 each  head entry fields.
REQ-011 SHALL have ports log_carry, log_borrow  output  1 each  head entry flags.
REQ-012 SHALL have port count  output  $clog2(DEPTH)+1  number of stored entries.
REQ-013 SHALL have port overflow  output  1  sticky flag: a capture was dropped.

Function
REQ-014 SHALL register result_ready into rr_q each cycle; push = result_ready & ~rr_q.
REQ-015 SHALL store one 42-bit entry {pc, opcode, A, B, result, carry, borrow} per push, sampled in the push cycle.
REQ-016 SHALL present entries first-in first-out; the head is shown combinationally from storage (show-ahead).
REQ-017 SHALL assert log_valid in cycle n+1 for a push in cycle n into an empty log (latency 1).
REQ-018 SHALL pop the head when log_valid & log_ready; the next entry appears in the following cycle.
REQ-019 SHALL hold head outputs stable while log_valid=1 and log_ready=0.
REQ-020 SHALL wrap read and write pointers modulo DEPTH.
REQ-021 SHALL, when full with a push and no pop, drop the capture, leave contents unchanged and set overflow.
REQ-022 SHALL, when full with simultaneous push and pop, accept both; count stays DEPTH and overflow is not set.
REQ-023 SHALL, with simultaneous push and pop at 0 < count < DEPTH, keep count unchanged.
REQ-024 SHALL ignore log_ready while empty; count never underflows.
REQ-025 SHALL drive head outputs to 0 while log_valid=0.
REQ-026 SHALL give clear priority over push and pop: pointers, count and overflow go to 0 next cycle; rr_q still tracks result_ready.
REQ-027 SHALL produce exactly one push for a result_ready level held high over many cycles.

Reset
REQ-028 SHALL, with rst=1 at a clock edge, set pointers, count, overflow and rr_q to 0; log_valid=0 and all head outputs 0 in the next cycle.
REQ-029 SHALL let rst override clear, push and pop, including when asserted mid-stream with entries pending; storage contents need no reset.
REQ-030 SHALL, when result_ready is already high as rst deasserts, treat the first post-reset cycle as a rising edge (rr_q=0) and push.

Structure
REQ-031 SHALL put the entry width (42), field bit offsets and default DEPTH in a shared package, logger_pkg.
REQ-032 SHALL implement storage as one sub-module, logger_ram (DEPTH x 42, one synchronous write port, one asynchronous read port); all control stays in result_logger.

Verification
REQ-033 SHALL cover: reset, then a one-cycle result_ready pulse with pc=3, opcode=8'b0000_0001, A=5, B=7, result=12 -> next cycle log_valid=1 with those fields and count=1.
REQ-034 SHALL cover: result_ready held high for 10 cycles -> exactly one entry and count=1.
REQ-035 SHALL cover: 9 pulses with DEPTH=8 and log_ready=0 -> count=8, overflow=1, the head equals the first capture, and the 9th capture is absent.
REQ-036 SHALL cover: full log, push and pop in the same cycle -> count=8, overflow=0, the new entry is last after 8 pops, and pointers wrap correctly.
REQ-037 SHALL cover: 3 entries pending, rst pulsed for one cycle -> count=0, log_valid=0 and outputs 0; a later pulse logs normally.
REQ-038 SHALL cover: clear with a simultaneous push and pop at count=4 -> count=0 and overflow=0 next cycle.

Source files
------------

// File: rtl/logger_pkg.sv
// rtl/logger_pkg.sv - shared entry layout and defaults for the result logger
// Contents: entry width, field bit offsets, default depth, entry pack helper.
package logger_pkg;

  localparam int DEFAULT_DEPTH = 8;
  localparam int ENTRY_W       = 42;

  // Entry layout, MSB to LSB: {pc, opcode, A, B, result, carry, borrow}
  localparam int PC_LSB     = 34;
  localparam int OPCODE_LSB = 26;
  localparam int A_LSB      = 18;
  localparam int B_LSB      = 10;
  localparam int RESULT_LSB = 2;
  localparam int CARRY_BIT  = 1;
  localparam int BORROW_BIT = 0;

  function automatic logic [ENTRY_W-1:0] pack_entry(
    input logic [7:0] pc,
    input logic [7:0] opcode,
    input logic [7:0] a,
    input logic [7:0] b,
    input logic [7:0] result,
    input logic       carry,
    input logic       borrow
  );
    return {pc, opcode, a, b, result, carry, borrow};
  endfunction

endpackage

// File: rtl/logger_ram.sv
// rtl/logger_ram.sv - DEPTH x 42 entry storage, sync write, async read
// Ports: clk; we/waddr/wdata write port; raddr/rdata combinational read port.
module logger_ram
  import logger_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               we,
  input  logic [AW-1:0]      waddr,
  input  logic [ENTRY_W-1:0] wdata,
  input  logic [AW-1:0]      raddr,
  output logic [ENTRY_W-1:0] rdata
);

  logic [ENTRY_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/result_logger.sv
// rtl/result_logger.sv - FIFO log of CPU results captured on result_ready rising edges
// Ports: clk, rst (sync, active-high), clear (flush);
//        result_ready + pc/opcode/operand_A/operand_B/result/carry/borrow capture inputs;
//        log_valid/log_ready handshake with show-ahead head fields log_*;
//        count (stored entries), overflow (sticky dropped-capture flag).
module result_logger
  import logger_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic                     result_ready,
  input  logic [7:0]               pc_in,
  input  logic [7:0]               opcode_in,
  input  logic [7:0]               operand_A_in,
  input  logic [7:0]               operand_B_in,
  input  logic [7:0]               result_in,
  input  logic                     carry_in,
  input  logic                     borrow_in,
  input  logic                     log_ready,
  output logic                     log_valid,
  output logic [7:0]               log_pc,
  output logic [7:0]               log_opcode,
  output logic [7:0]               log_A,
  output logic [7:0]               log_B,
  output logic [7:0]               log_result,
  output logic                     log_carry,
  output logic                     log_borrow,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;

  logic               rr_q;
  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      rd_ptr;
  logic [CW-1:0]      count_q;
  logic               overflow_q;

  logic               push;
  logic               pop;
  logic               full;
  logic               do_write;
  logic [ENTRY_W-1:0] wdata;
  logic [ENTRY_W-1:0] rdata;

  // One push per rising edge of the result_ready level.
  assign push = result_ready & ~rr_q;
  assign pop  = log_valid & log_ready;
  assign full = (count_q == CW'(DEPTH));

  // A full log still accepts a capture when the head leaves in the same cycle.
  assign do_write = push & (~full | pop);

  assign wdata = pack_entry(pc_in, opcode_in, operand_A_in, operand_B_in,
                            result_in, carry_in, borrow_in);

  logger_ram #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .we    (do_write & ~clear & ~rst),
    .waddr (wr_ptr),
    .wdata (wdata),
    .raddr (rd_ptr),
    .rdata (rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_q       <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      // Edge tracking continues through clear so a held level is not re-pushed.
      rr_q <= result_ready;
      if (clear) begin
        wr_ptr     <= '0;
        rd_ptr     <= '0;
        count_q    <= '0;
        overflow_q <= 1'b0;
      end else begin
        if (do_write) begin
          wr_ptr <= wr_ptr + AW'(1);
        end
        if (pop) begin
          rd_ptr <= rd_ptr + AW'(1);
        end
        case ({do_write, pop})
          2'b10:   count_q <= count_q + CW'(1);
          2'b01:   count_q <= count_q - CW'(1);
          default: count_q <= count_q;
        endcase
        if (push & full & ~pop) begin
          overflow_q <= 1'b1;
        end
      end
    end
  end

  assign log_valid  = (count_q != '0);
  assign count      = count_q;
  assign overflow   = overflow_q;

  assign log_pc     = log_valid ? rdata[PC_LSB +: 8]     : 8'h00;
  assign log_opcode = log_valid ? rdata[OPCODE_LSB +: 8] : 8'h00;
  assign log_A      = log_valid ? rdata[A_LSB +: 8]      : 8'h00;
  assign log_B      = log_valid ? rdata[B_LSB +: 8]      : 8'h00;
  assign log_result = log_valid ? rdata[RESULT_LSB +: 8] : 8'h00;
  assign log_carry  = log_valid & rdata[CARRY_BIT];
  assign log_borrow = log_valid & rdata[BORROW_BIT];

endmodule

// File: tb/tb_result_logger.sv
// tb/tb_result_logger.sv - self-checking scoreboard bench for result_logger
module tb_result_logger;

  logic       clk;
  logic       rst;
  logic       clear;
  logic       result_ready;
  logic [7:0] pc_in, opcode_in, operand_A_in, operand_B_in, result_in;
  logic       carry_in, borrow_in;
  logic       log_ready;
  logic       log_valid;
  logic [7:0] log_pc, log_opcode, log_A, log_B, log_result;
  logic       log_carry, log_borrow;
  logic [3:0] count;
  logic       overflow;

  logic [41:0] sb[$];
  int          n_checks;
  int          n_fail;

  wire [41:0] head = {log_pc, log_opcode, log_A, log_B, log_result, log_carry, log_borrow};

  result_logger #(.DEPTH(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .clear        (clear),
    .result_ready (result_ready),
    .pc_in        (pc_in),
    .opcode_in    (opcode_in),
    .operand_A_in (operand_A_in),
    .operand_B_in (operand_B_in),
    .result_in    (result_in),
    .carry_in     (carry_in),
    .borrow_in    (borrow_in),
    .log_ready    (log_ready),
    .log_valid    (log_valid),
    .log_pc       (log_pc),
    .log_opcode   (log_opcode),
    .log_A        (log_A),
    .log_B        (log_B),
    .log_result   (log_result),
    .log_carry    (log_carry),
    .log_borrow   (log_borrow),
    .count        (count),
    .overflow     (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_fields(input logic [41:0] e);
    {pc_in, opcode_in, operand_A_in, operand_B_in, result_in, carry_in, borrow_in} = e;
  endtask

  function automatic logic [41:0] rand_entry();
    logic [63:0] t;
    t = {$urandom, $urandom};
    return t[41:0];
  endfunction

  // One-cycle result_ready pulse followed by one low cycle; kept entries go to the scoreboard.
  task automatic pulse(input logic [41:0] e, input bit kept);
    drive_fields(e);
    result_ready = 1'b1;
    step();
    result_ready = 1'b0;
    step();
    if (kept) sb.push_back(e);
  endtask

  task automatic test_reset();
    rst = 1'b1; clear = 1'b0; result_ready = 1'b0; log_ready = 1'b0;
    drive_fields('0);
    step(); step();
    rst = 1'b0;
    step();
    n_checks++;
    if (log_valid !== 1'b0 || count !== 4'd0 || overflow !== 1'b0 || head !== 42'd0) begin
      n_fail++;
      $display("FAIL reset_state: valid=%b count=%0d ovf=%b head=%h, required 0 0 0 0",
               log_valid, count, overflow, head);
    end
  endtask

  task automatic test_single_capture();
    logic [41:0] e;
    e = {8'd3, 8'b0000_0001, 8'd5, 8'd7, 8'd12, 1'b0, 1'b0};
    drive_fields(e);
    result_ready = 1'b1;
    step();
    sb.push_back(e);
    n_checks++;
    if (log_valid !== 1'b1 || count !== 4'd1 || head !== sb[0]) begin
      n_fail++;
      $display("FAIL single_capture: valid=%b count=%0d head=%h, required 1 1 %h",
               log_valid, count, head, sb[0]);
    end
    result_ready = 1'b0;
    step();
    n_checks++;
    if (head !== sb[0]) begin
      n_fail++;
      $display("FAIL head_stable: head=%h, required %h", head, sb[0]);
    end
    log_ready = 1'b1;
    step();
    log_ready = 1'b0;
    void'(sb.pop_front());
    n_checks++;
    if (log_valid !== 1'b0 || count !== 4'd0 || head !== 42'd0) begin
      n_fail++;
      $display("FAIL single_pop: valid=%b count=%0d head=%h, required 0 0 0",
               log_valid, count, head);
    end
  endtask

  task automatic test_empty_pop();
    log_ready = 1'b1;
    step(); step(); step();
    log_ready = 1'b0;
    n_checks++;
    if (count !== 4'd0 || log_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL empty_pop: count=%0d valid=%b, required 0 0", count, log_valid);
    end
  endtask

  task automatic test_level_hold();
    logic [41:0] first;
    first = rand_entry();
    drive_fields(first);
    result_ready = 1'b1;
    step();
    for (int i = 1; i < 10; i++) begin
      drive_fields(rand_entry());
      step();
    end
    result_ready = 1'b0;
    step();
    sb.push_back(first);
    n_checks++;
    if (count !== 4'd1 || head !== sb[0]) begin
      n_fail++;
      $display("FAIL level_hold: count=%0d head=%h, required 1 %h", count, head, sb[0]);
    end
    log_ready = 1'b1;
    step();
    log_ready = 1'b0;
    void'(sb.pop_front());
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 9; i++) pulse(rand_entry(), i < 8);
    n_checks++;
    if (count !== 4'd8 || overflow !== 1'b1 || head !== sb[0]) begin
      n_fail++;
      $display("FAIL overflow_full: count=%0d ovf=%b head=%h, required 8 1 %h",
               count, overflow, head, sb[0]);
    end
    for (int i = 0; i < 8; i++) begin
      n_checks++;
      if (log_valid !== 1'b1 || head !== sb[0]) begin
        n_fail++;
        $display("FAIL overflow_drain[%0d]: valid=%b head=%h, required 1 %h",
                 i, log_valid, head, sb[0]);
      end
      void'(sb.pop_front());
      log_ready = 1'b1;
      step();
      log_ready = 1'b0;
    end
    n_checks++;
    if (count !== 4'd0 || log_valid !== 1'b0 || overflow !== 1'b1) begin
      n_fail++;
      $display("FAIL overflow_sticky: count=%0d valid=%b ovf=%b, required 0 0 1",
               count, log_valid, overflow);
    end
    clear = 1'b1;
    step();
    clear = 1'b0;
    n_checks++;
    if (overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL clear_overflow: ovf=%b, required 0", overflow);
    end
  endtask

  task automatic test_full_push_pop();
    logic [41:0] e;
    for (int i = 0; i < 8; i++) pulse(rand_entry(), 1'b1);
    e = rand_entry();
    drive_fields(e);
    result_ready = 1'b1;
    log_ready = 1'b1;
    step();
    result_ready = 1'b0;
    log_ready = 1'b0;
    void'(sb.pop_front());
    sb.push_back(e);
    n_checks++;
    if (count !== 4'd8 || overflow !== 1'b0 || head !== sb[0]) begin
      n_fail++;
      $display("FAIL full_push_pop: count=%0d ovf=%b head=%h, required 8 0 %h",
               count, overflow, head, sb[0]);
    end
    step();
    for (int i = 0; i < 8; i++) begin
      n_checks++;
      if (log_valid !== 1'b1 || head !== sb[0]) begin
        n_fail++;
        $display("FAIL wrap_drain[%0d]: valid=%b head=%h, required 1 %h",
                 i, log_valid, head, sb[0]);
      end
      void'(sb.pop_front());
      log_ready = 1'b1;
      step();
      log_ready = 1'b0;
    end
    n_checks++;
    if (count !== 4'd0 || log_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL wrap_empty: count=%0d valid=%b, required 0 0", count, log_valid);
    end
  endtask

  task automatic test_reset_midstream();
    logic [41:0] e;
    for (int i = 0; i < 3; i++) pulse(rand_entry(), 1'b1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    sb.delete();
    n_checks++;
    if (count !== 4'd0 || log_valid !== 1'b0 || head !== 42'd0 || overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_midstream: count=%0d valid=%b head=%h ovf=%b, required 0 0 0 0",
               count, log_valid, head, overflow);
    end
    e = rand_entry();
    pulse(e, 1'b1);
    n_checks++;
    if (count !== 4'd1 || head !== sb[0]) begin
      n_fail++;
      $display("FAIL post_reset_capture: count=%0d head=%h, required 1 %h", count, head, sb[0]);
    end
    log_ready = 1'b1;
    step();
    log_ready = 1'b0;
    void'(sb.pop_front());
  endtask

  task automatic test_reset_rr_high();
    logic [41:0] e;
    e = rand_entry();
    drive_fields(e);
    result_ready = 1'b1;
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    sb.push_back(e);
    n_checks++;
    if (count !== 4'd1 || head !== sb[0]) begin
      n_fail++;
      $display("FAIL reset_rr_high: count=%0d head=%h, required 1 %h", count, head, sb[0]);
    end
    result_ready = 1'b0;
    log_ready = 1'b1;
    step();
    log_ready = 1'b0;
    void'(sb.pop_front());
  endtask

  task automatic test_clear_push_pop();
    logic [41:0] e;
    for (int i = 0; i < 4; i++) pulse(rand_entry(), 1'b1);
    e = rand_entry();
    drive_fields(e);
    result_ready = 1'b1;
    log_ready = 1'b1;
    step();
    result_ready = 1'b0;
    log_ready = 1'b0;
    void'(sb.pop_front());
    sb.push_back(e);
    n_checks++;
    if (count !== 4'd4 || head !== sb[0]) begin
      n_fail++;
      $display("FAIL mid_push_pop: count=%0d head=%h, required 4 %h", count, head, sb[0]);
    end
    step();
    drive_fields(rand_entry());
    result_ready = 1'b1;
    log_ready = 1'b1;
    clear = 1'b1;
    step();
    result_ready = 1'b0;
    log_ready = 1'b0;
    clear = 1'b0;
    sb.delete();
    n_checks++;
    if (count !== 4'd0 || overflow !== 1'b0 || log_valid !== 1'b0 || head !== 42'd0) begin
      n_fail++;
      $display("FAIL clear_push_pop: count=%0d ovf=%b valid=%b head=%h, required 0 0 0 0",
               count, overflow, log_valid, head);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_single_capture();
    test_empty_pop();
    test_level_hold();
    test_overflow();
    test_full_push_pop();
    test_reset_midstream();
    test_reset_rr_high();
    test_clear_push_pop();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
